// File: rtl/seq_core.sv
// seq_core: program sequencer with synchronous ROM fetch and branches.
// Define SEQ_CORE_STACK_EN to build the call/return stack.
module seq_core #(
  parameter int unsigned PC_W        = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_PC    = 0,
  localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              run,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_data,
  output logic [15:0]       ir,
  output logic              ir_valid,
  output logic [PC_W-1:0]   pc,
  input  logic              jmp,
  input  logic              jmp_rel,
  input  logic              call,
  input  logic              ret,
  input  logic [DATA_W-1:0] target,
  output logic [SP_W-1:0]   sp,
  output logic              stack_err,
  output logic              busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

  logic [2:0]      state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_next_q;
  logic [15:0]     ir_q;
  logic            ir_valid_q;
  logic            exec;
  logic            fault;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_abs;
  logic [PC_W-1:0] pc_rel;
  logic [PC_W-1:0] exec_pc;

  assign exec   = state_q == S_EXEC;
  assign pc_inc = pc_q + PC_W'(1);
  assign pc_abs = PC_W'(target);
  assign pc_rel = pc_q + PC_W'($signed(target));

`ifdef SEQ_CORE_STACK_EN
  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

  logic [PC_W-1:0] stack_q [STACK_DEPTH];
  logic [SP_W-1:0] sp_q;
  logic [SP_W-1:0] sp_dec;
  logic            err_q;
  logic            push;
  logic            pop;

  assign sp_dec = sp_q - SP_W'(1);

  // ret outranks call, call outranks jmp
  always_comb begin
    exec_pc = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    fault   = 1'b0;
    if (ret) begin
      if (sp_q == '0) begin
        fault = 1'b1;
      end else begin
        pop     = 1'b1;
        exec_pc = stack_q[sp_dec[IDX_W-1:0]];
      end
    end else if (call) begin
      if (sp_q == SP_W'(STACK_DEPTH)) begin
        fault = 1'b1;
      end else begin
        push    = 1'b1;
        exec_pc = pc_abs;
      end
    end else if (jmp) begin
      exec_pc = jmp_rel ? pc_rel : pc_abs;
    end
  end

  always_ff @(posedge clk) begin
    if (exec && push) begin
      stack_q[sp_q[IDX_W-1:0]] <= pc_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else if (exec) begin
      if (fault) begin
        err_q <= 1'b1;
      end else if (push) begin
        sp_q <= sp_q + SP_W'(1);
      end else if (pop) begin
        sp_q <= sp_dec;
      end
    end
  end

  assign sp        = sp_q;
  assign stack_err = err_q;
`else
  logic unused_ctl;
  assign unused_ctl = call | ret;

  always_comb begin
    exec_pc = pc_inc;
    if (jmp) begin
      exec_pc = jmp_rel ? pc_rel : pc_abs;
    end
  end

  assign fault     = 1'b0;
  assign sp        = '0;
  assign stack_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RST_PC;
      pc_next_q  <= RST_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      ir_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (step || run) state_q <= S_FETCH;
        end
        S_FETCH: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          ir_q       <= imem_data;
          pc_q       <= pc_next_q;
          ir_valid_q <= 1'b1;
          state_q    <= S_EXEC;
        end
        S_EXEC: begin
          if (fault) begin
            state_q <= S_HALT;
          end else begin
            pc_next_q <= exec_pc;
            state_q   <= run ? S_FETCH : S_IDLE;
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ROM address tracks pc_next so it is stable for the whole FETCH cycle
  assign imem_addr = pc_next_q;
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign pc        = pc_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule

// File: tb/tb_seq_core.sv
// tb_seq_core: scoreboard bench for seq_core.
// Program ROM opcodes: 0 nop, 1 jmp, 2 jmp_rel, 3 call, 4 ret, 5 call+jmp.
module tb_seq_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        step = 1'b0;
  logic        run = 1'b0;
  logic [15:0] imem_addr;
  logic [15:0] imem_data = '0;
  logic [15:0] ir;
  logic        ir_valid;
  logic [15:0] pc;
  logic        jmp;
  logic        jmp_rel;
  logic        call;
  logic        ret;
  logic [7:0]  target;
  logic [2:0]  sp;
  logic        stack_err;
  logic        busy;

  logic        step_w = 1'b0;
  logic [15:0] imem_addr_w;
  logic [15:0] imem_data_w = '0;
  logic [15:0] ir_w;
  logic        ir_valid_w;
  logic [15:0] pc_w;
  logic [2:0]  sp_w;
  logic        err_w;
  logic        busy_w;
  logic        zero_w = 1'b0;
  logic [7:0]  tgt_w = '0;

  logic [15:0] rom [0:65535];

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ir;
    logic [7:0]  sp;
  } exp_t;

  exp_t        q[$];
  logic [31:0] wq[$];
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  seq_core #(
    .PC_W(16), .DATA_W(8), .STACK_DEPTH(4), .RESET_PC(0)
  ) u_dut (
    .clk(clk), .reset(reset), .step(step), .run(run),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .ir(ir), .ir_valid(ir_valid), .pc(pc),
    .jmp(jmp), .jmp_rel(jmp_rel), .call(call), .ret(ret),
    .target(target), .sp(sp), .stack_err(stack_err),
    .busy(busy)
  );

  seq_core #(
    .PC_W(16), .DATA_W(8), .STACK_DEPTH(4), .RESET_PC(65535)
  ) u_wrap (
    .clk(clk), .reset(reset), .step(step_w), .run(zero_w),
    .imem_addr(imem_addr_w), .imem_data(imem_data_w),
    .ir(ir_w), .ir_valid(ir_valid_w), .pc(pc_w),
    .jmp(zero_w), .jmp_rel(zero_w), .call(zero_w),
    .ret(zero_w), .target(tgt_w), .sp(sp_w),
    .stack_err(err_w), .busy(busy_w)
  );

  always @(posedge clk) begin
    imem_data   <= rom[imem_addr];
    imem_data_w <= rom[imem_addr_w];
  end

  // datapath stand-in: decode the latched instruction
  assign target  = ir[7:0];
  assign jmp     = ir_valid && (ir[15:12] inside {4'd1, 4'd2, 4'd5});
  assign jmp_rel = ir[15:12] == 4'd2;
  assign call    = ir_valid && (ir[15:12] inside {4'd3, 4'd5});
  assign ret     = ir_valid && (ir[15:12] == 4'd4);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic e(input logic [15:0] p, input logic [15:0] i,
                   input logic [7:0] s);
    exp_t x;
    x.pc = p;
    x.ir = i;
    x.sp = s;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (ir_valid) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_issue: pc %h ir %h, none expected",
                 pc, ir);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("issue_pc", 32'(pc), 32'(x.pc));
        chk("issue_ir", 32'(ir), 32'(x.ir));
        chk("issue_sp", 32'(sp), 32'(x.sp));
      end
    end
  end

  always @(negedge clk) begin
    if (ir_valid_w) begin
      if (wq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_wrap_issue: pc %h ir %h", pc_w, ir_w);
      end else begin
        chk("wrap_issue", {pc_w, ir_w}, wq.pop_front());
      end
    end
  end

  task automatic step_i(input bit ex, input bit poke);
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    @(negedge clk);
    chk("lat_load_valid", 32'(ir_valid), 32'd0);
    chk("lat_load_busy", 32'(busy), 32'(ex));
    if (poke) step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("lat_exec_valid", 32'(ir_valid), 32'(ex));
    repeat (3) @(negedge clk);
  endtask

  task automatic run_n(input int n);
    @(negedge clk) run = 1'b1;
    for (int k = 0; k < n; k++) begin
      int c;
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!ir_valid && c < 20);
      chk("run_cadence", c, 3);
      if (!ir_valid) begin
        run = 1'b0;
        break;
      end
      if (k == n - 1) run = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk("run_idle", 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, 32'(pc), 32'h0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'h0);
    chk({tag, "_ir"}, 32'(ir), 32'h0);
    chk({tag, "_valid"}, 32'(ir_valid), 32'h0);
    chk({tag, "_sp"}, 32'(sp), 32'h0);
    chk({tag, "_err"}, 32'(stack_err), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 65536; a++) begin
      rom[a] = 16'h0500 | 16'(a[7:0]);
    end
    rom[16'h04] = 16'h3010;
    rom[16'h10] = 16'h4000;
    rom[16'h05] = 16'h1020;
    rom[16'h20] = 16'h5030;
    rom[16'h30] = 16'h4000;
    rom[16'h22] = 16'h1005;
    rom[16'h32] = 16'h1005;
    rom[16'h40] = 16'h3041;
    rom[16'h41] = 16'h3042;
    rom[16'h42] = 16'h3043;
    rom[16'h43] = 16'h3044;
    rom[16'h44] = 16'h3045;

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    chk("rst_wrap_pc", 32'(pc_w), 32'hFFFF);
    reset = 1'b1;

    // RESET_PC=0xFFFF instance: sequential execute wraps to 0
    wq.push_back({16'hFFFF, 16'h05FF});
    wq.push_back({16'h0000, 16'h0500});
    repeat (2) begin
      @(negedge clk) step_w = 1'b1;
      @(negedge clk) step_w = 1'b0;
      repeat (4) @(negedge clk);
    end
    chk("wrap_addr", 32'(imem_addr_w), 32'h0001);

    e(16'h0, 16'h0500, 0);
    e(16'h1, 16'h0501, 0);
    e(16'h2, 16'h0502, 0);
    step_i(1, 1);
    step_i(1, 0);
    step_i(1, 0);

`ifdef SEQ_CORE_STACK_EN
    e(16'h03, 16'h0503, 0);
    e(16'h04, 16'h3010, 0);
    e(16'h10, 16'h4000, 1);
    e(16'h05, 16'h1020, 0);
    e(16'h20, 16'h5030, 0);
    e(16'h30, 16'h4000, 1);
    e(16'h21, 16'h0521, 0);
    run_n(7);
    e(16'h22, 16'h1005, 0);
`else
    e(16'h03, 16'h0503, 0);
    e(16'h04, 16'h3010, 0);
    e(16'h05, 16'h1020, 0);
    e(16'h20, 16'h5030, 0);
    e(16'h30, 16'h4000, 0);
    e(16'h31, 16'h0531, 0);
    run_n(6);
    e(16'h32, 16'h1005, 0);
`endif

    rom[16'h05] = 16'h20FE;
    rom[16'h03] = 16'h1040;
    e(16'h05, 16'h20FE, 0);
    e(16'h03, 16'h1040, 0);
    repeat (3) step_i(1, 0);
    chk("rel_target", 32'(imem_addr), 32'h0040);

    // reset while the fetched word sits in LOAD
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk_reset_vals("load_rst");
    @(negedge clk) reset = 1'b1;

    rom[16'h00] = 16'h1040;
    e(16'h00, 16'h1040, 0);
    step_i(1, 0);

`ifdef SEQ_CORE_STACK_EN
    for (int k = 0; k < 5; k++) begin
      e(16'h40 + 16'(k), 16'h3041 + 16'(k), 8'(k));
    end
    repeat (5) step_i(1, 0);
    chk("ovf_err", 32'(stack_err), 32'd1);
    chk("ovf_sp", 32'(sp), 32'd4);
    chk("ovf_busy", 32'(busy), 32'd0);
    step_i(0, 0);
    chk("halt_addr", 32'(imem_addr), 32'h0044);
`else
    for (int k = 0; k < 5; k++) begin
      e(16'h40 + 16'(k), 16'h3041 + 16'(k), 0);
    end
    repeat (5) step_i(1, 0);
    chk("ovf_err", 32'(stack_err), 32'd0);
    chk("ovf_sp", 32'(sp), 32'd0);
    chk("ovf_busy", 32'(busy), 32'd0);
    e(16'h45, 16'h0545, 0);
    step_i(1, 0);
    chk("halt_addr", 32'(imem_addr), 32'h0046);
`endif

    @(negedge clk) reset = 1'b0;
    #1;
    chk("rst2_sp", 32'(sp), 32'd0);
    chk("rst2_err", 32'(stack_err), 32'd0);
    @(negedge clk) reset = 1'b1;

    rom[16'h00] = 16'h4000;
    e(16'h00, 16'h4000, 0);
    step_i(1, 0);
`ifdef SEQ_CORE_STACK_EN
    chk("udf_err", 32'(stack_err), 32'd1);
    chk("udf_busy", 32'(busy), 32'd0);
    step_i(0, 0);
`else
    chk("udf_err", 32'(stack_err), 32'd0);
    chk("udf_busy", 32'(busy), 32'd0);
    e(16'h01, 16'h0501, 0);
    step_i(1, 0);
`endif

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(q.size() + wq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_core.md
# seq_core

Parametrised program sequencer for the lab CPU: owns the program counter, fetches from a synchronous instruction ROM, and issues one instruction per step or continuously in run mode. It adds relative branches and a call/return stack. It sits between the debounced front-panel buttons and the decoder/register bank/ALU datapath, and runs on the system clock rather than on a button-derived clock.

## Interface
- PC_W, 16, program counter and instruction address width
- DATA_W, 8, width of the `target` operand from the ALU
- STACK_DEPTH, 4, return-stack entries (≥2)
- RESET_PC, 0, PC value loaded at reset

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- step  in  1  one-cycle pulse (already debounced/edge-detected): execute one instruction
- run  in  1  level: fetch/execute continuously while high
- imem_addr  out  PC_W  ROM address (registered)
- imem_data  in  16  ROM data, valid the cycle after `imem_addr` changes
- ir  out  16  latched instruction
- ir_valid  out  1  one-cycle execute strobe; datapath write enable is qualified by this
- pc  out  PC_W  address of the instruction held in `ir`
- jmp  in  1  absolute jump to `target` (zero-extended to PC_W)
- jmp_rel  in  1  with `jmp`: relative branch, `pc + sext(target)`
- call  in  1  push `pc+1`, jump to zero-extended `target`
- ret  in  1  pop PC from stack
- target  in  DATA_W  jump/call operand (ALU result)
- sp  out  $clog2(STACK_DEPTH+1)  stack occupancy
- stack_err  out  1  sticky overflow/underflow flag
- busy  out  1  high in every state except IDLE and HALT

## Operation
- States: IDLE, FETCH, LOAD, EXEC, HALT.
- IDLE: on `step` or `run` → FETCH; otherwise hold.
- FETCH: `imem_addr` presents `pc_next`; → LOAD.
- LOAD: capture `imem_data` into `ir` and `pc_next` into `pc`; → EXEC.
- EXEC: `ir_valid`=1 for exactly this cycle; sample control inputs at the end of the cycle:
  - ret > call > jmp priority when multiple inputs are asserted together.
  - ret: `pc_next` ← stack top, sp−1; when sp=0, set `stack_err` and go → HALT.
  - call: push `pc+1`, sp+1, `pc_next` ← target; when sp=STACK_DEPTH, set `stack_err` and go → HALT, with no push.
  - jmp: `pc_next` ← target, or `pc + sext(target)` when `jmp_rel` is high.
  - none asserted: `pc_next` ← `pc+1`.
  - Next state → FETCH if `run` is high, else → IDLE.
- All PC arithmetic is modulo 2^PC_W; `0xFFFF+1` wraps to 0, and relative branches wrap the same way.
- HALT: outputs frozen, `ir_valid`=0; only `reset` exits.
- `step` pulses arriving while `busy` is high are ignored; there is no queuing.
- Dropping `run` mid-instruction completes the current instruction, then → IDLE.

## Timing
- Reset values: state IDLE, `pc`=`pc_next`=`imem_addr`=RESET_PC, `ir`=0, `ir_valid`=0, `sp`=0, `stack_err`=0, `busy`=0.
- Reset assertion takes effect immediately, including mid-instruction; the stack is discarded.
- Latency from `step` to `ir_valid` is 3 cycles (IDLE→FETCH→LOAD→EXEC).
- Run mode issues one instruction every 3 cycles.
- Control inputs are required only in the EXEC cycle and are don't-care elsewhere.
- A branch's target instruction appears in `ir` 3 cycles after its EXEC cycle.
- ROM read latency is exactly 1 cycle; there is no wait-state handshake.

## Configuration
- `SEQ_CORE_STACK_EN` defined: call/return stack, `sp`, and `stack_err` are implemented as described above.
- Not defined: no stack storage is built.
  - `call` and `ret` are ignored, and a cycle with only those asserted advances `pc+1`.
  - `sp`=0 and `stack_err`=0 are tied off.
  - HALT is unreachable.

## Test plan
- Reset, ROM[0..2]=A,B,C, three `step` pulses: `ir`=A,B,C with `pc`=0,1,2; `ir_valid` 3 cycles after each pulse; `step` pulses during busy are ignored.
- `run`=1, ROM[5] asserts `jmp` with target=0x20: `pc` sequence 5 → 0x20; with `jmp_rel`, target=0xFE at pc=5 gives next pc=3.
- call at pc=4 with target=0x10, then ret at 0x10: `sp` goes 1 → 0 and execution resumes at pc=5; `call`+`jmp` asserted together behaves as the call.
- STACK_DEPTH=4 with five nested calls: fifth call sets `stack_err`, enters HALT, `sp` stays 4; `ret` at sp=0 also halts.
- RESET_PC=0xFFFF, sequential execute: `pc` wraps to 0x0000.
- Assert `reset` low during LOAD: all outputs return to reset values asynchronously; after release, the first `step` fetches from RESET_PC.
